// File: rtl/xbee_pkg.sv
// Shared definitions for the XBee event scheduler: FSM encoding, colour codes and the
// packed layout of one queued detection event.
package xbee_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StLaunch    = 2'd1,
    StWaitStart = 2'd2,
    StWaitEnd   = 2'd3
  } state_e;

  // Supply colour codes understood by the transmitter; any other value reports CS
  localparam logic [2:0] ColFire = 3'd1;
  localparam logic [2:0] ColCt   = 3'd2;

  // Event field widths
  localparam int unsigned ColorW   = 3;
  localparam int unsigned NodeNumW = 4;

  // One queued event. Packed MSB first: {nodex, node_num, color} -> bits [7], [6:3], [2:0].
  typedef struct packed {
    logic                nodex;
    logic [NodeNumW-1:0] node_num;
    logic [ColorW-1:0]   color;
  } event_t;

  localparam int unsigned EventW = $bits(event_t);

  // Width of a saturating counter able to reach the larger of two limits
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/xbee_event_fifo.sv
// Synchronous event FIFO, DEPTH x WIDTH, with registered occupancy.
// Full/empty are derived from the occupancy register, so a pop in the same cycle as a push
// never makes room for that push; the push is simply refused while full.
module xbee_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CountW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally at a power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset
  always_ff @(posedge CLOCK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/xbee_event_scheduler.sv
// XBee event scheduler: queues detection events and launches one transmitter message per
// event. The transmitter samples COLOR/NODEX/NODE_NUM live while it sends, so those are held
// in registers that only change when the next event is popped.
module xbee_event_scheduler
  import xbee_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned QUIET_CYCLES = 4,
  parameter int unsigned START_TMO    = 64
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       EV_VALID,
  output logic       EV_READY,
  input  logic [2:0] EV_COLOR,
  input  logic       EV_NODEX,
  input  logic [3:0] EV_NODE_NUM,
  input  logic       TX_DONE,
  output logic       DETECT,
  output logic [2:0] COLOR,
  output logic       NODEX,
  output logic [3:0] NODE_NUM,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic       TMO_ERR
);

  localparam int unsigned CntW = cnt_width(START_TMO, QUIET_CYCLES);

  // Last counter value of each wait, i.e. the cycle on which the wait ends
  localparam logic [CntW-1:0] TmoLast   = CntW'(START_TMO - 1);
  localparam logic [CntW-1:0] QuietLast = CntW'(QUIET_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  event_t            held_q, head, ev_in;
  logic [EventW-1:0] fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              launch_ok, tmo_hit, quiet_hit;

  // Event queue
  assign ev_in      = '{nodex: EV_NODEX, node_num: EV_NODE_NUM, color: EV_COLOR};
  assign fifo_wdata = ev_in;
  assign head       = event_t'(fifo_rdata);

  // EV_READY is the registered not-full, so an offer while full is dropped even if the
  // FSM pops in the same cycle
  assign EV_READY = ~fifo_full;
  assign push     = EV_VALID & ~fifo_full;
  assign OVERFLOW = EV_VALID & fifo_full;

  xbee_event_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EventW)
  ) u_fifo (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .push   (push),
    .pop    (pop),
    .wdata  (fifo_wdata),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Launch and wait-end conditions shared by next-state and output logic
  always_comb begin
    cnt_inc   = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    launch_ok = (state_q == StIdle) && !fifo_empty && TX_DONE;
    tmo_hit   = (state_q == StWaitStart) && TX_DONE && (cnt_q >= TmoLast);
    quiet_hit = (state_q == StWaitEnd) && TX_DONE && (cnt_q >= QuietLast);
  end

  // FSM state and shared wait counter
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the counter times the start timeout in WAIT_START and counts consecutive
  // done-high cycles in WAIT_END, so a 1-2 cycle inter-character gap cannot end the message
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (launch_ok) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (!TX_DONE) begin
          cnt_d   = '0;
          state_d = StWaitEnd;
        end else if (tmo_hit) begin
          // Event is abandoned, not retried
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitEnd: begin
        if (!TX_DONE) begin
          cnt_d = '0;
        end else if (quiet_hit) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs: pop and launch pulse, busy flag, timeout pulse
  always_comb begin
    pop     = launch_ok;
    DETECT  = (state_q == StLaunch);
    BUSY    = (state_q != StIdle);
    TMO_ERR = tmo_hit;
  end

  // Held message fields, loaded only when the head event is popped
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      held_q <= '0;
    end else if (pop) begin
      held_q <= head;
    end
  end

  assign COLOR    = held_q.color;
  assign NODEX    = held_q.nodex;
  assign NODE_NUM = held_q.node_num;

endmodule
